// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign correction on the final iteration.
module muldiv_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [REG_AW-1:0] rd_in,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   result,
    output logic [REG_AW-1:0] rd_out,
    output logic              wEn_out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [4:0]          counter;
    logic [2:0]          op_q;
    logic [REG_AW-1:0]   rd_q;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     opr;
    logic                neg_q;
    logic                neg_r;

    logic                signed_a, signed_b, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_by_zero, ovf, fast_hit;
    logic [XLEN-1:0]     fast_res;

    always_comb begin
        signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = signed_a && rs1_data[XLEN-1];
        b_neg    = signed_b && rs2_data[XLEN-1];
        a_mag    = a_neg ? -rs1_data : rs1_data;
        b_mag    = b_neg ? -rs2_data : rs2_data;

        div_by_zero = funct3[2] && (rs2_data == '0);
        ovf         = funct3[2] && !funct3[0] &&
                      (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
        fast_hit    = div_by_zero || ovf;
        if (div_by_zero)
            fast_res = funct3[1] ? rs1_data : '1;
        else
            fast_res = funct3[1] ? '0 : rs1_data;
    end

    // acc holds {partial product hi, multiplier} for MUL, {remainder, quotient} for DIV
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_trial;
    logic [XLEN:0]       div_diff;
    logic [2*XLEN-1:0]   acc_step;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix, final_res;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opr} : '0);
        div_trial = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_trial - {1'b0, opr};
        if (op_q[2]) begin
            if (div_trial >= {1'b0, opr})
                acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_step = {acc[2*XLEN-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end

        prod_fix = neg_q ? -acc_step : acc_step;
        quo_fix  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem_fix  = neg_r ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

        unique case (op_q)
            3'b000:                 final_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wEn_out <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            acc     <= '0;
            opr     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            done    <= 1'b0;
            wEn_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= funct3;
                        rd_q    <= rd_in;
                        counter <= '0;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        opr     <= funct3[2] ? b_mag : a_mag;
                        acc     <= {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
                        busy    <= 1'b1;
                        if (fast_hit) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            wEn_out <= (rd_in != '0);
                            result  <= fast_res;
                            rd_out  <= rd_in;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc     <= acc_step;
                    counter <= counter + 1'b1;
                    if (counter == '1) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        wEn_out <= (rd_q != '0);
                        result  <= final_res;
                        rd_out  <= rd_q;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases plus randomized operations
// checked against an arithmetic reference model, including completion timing.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        wEn_out;

    muldiv_unit #(.XLEN(32), .REG_AW(5)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_in    (rd_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out),
        .wEn_out  (wEn_out)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb2;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              q, r;
        sa = $signed(a);
        sb2 = $signed(b);
        ua = a;
        ub = b;
        case (f)
            3'b000: begin p = ua * ub;  return p[31:0];  end
            3'b001: begin p = sa * sb2; return p[63:32]; end
            3'b010: begin p = sa * ub;  return p[63:32]; end
            3'b011: begin p = ua * ub;  return p[63:32]; end
            default: begin
                if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
                if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return f[1] ? 32'd0 : a;
                if (!f[0]) begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    return f[1] ? r : q;
                end
                return f[1] ? (a % b) : (a / b);
            end
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Monitor: pops the scoreboard on every done pulse, flags stray or overdue completions
    always @(negedge clock) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done required=no_done (cycle %0d)", cyc);
            end else begin
                m_e = sb.pop_front();
                check("result", result, m_e.res);
                check("rd_out", {27'd0, rd_out}, {27'd0, m_e.rd});
                check("wEn_out", {31'd0, wEn_out}, {31'd0, m_e.wen});
                check("done_cycle", cyc, m_e.due);
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done_by_%0d (cycle %0d)",
                     sb[0].due, cyc);
            void'(sb.pop_front());
        end
    end

    // Waits at negedges until idle, spraying ignored start pulses and operand changes meanwhile
    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy) return;
            start    = 1'($urandom_range(0, 1));
            funct3   = 3'($urandom);
            rs1_data = $urandom;
            rs2_data = $urandom;
            rd_in    = 5'($urandom);
            @(negedge clock);
        end
        checks++;
        failures++;
        $display("FAIL idle_timeout actual=busy required=idle (cycle %0d)", cyc);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] req);
        exp_t e;
        wait_idle();
        start    = 1'b1;
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        e.res = req;
        e.rd  = rd;
        e.wen = (rd != 5'd0);
        e.due = cyc + (is_fast(f, a, b) ? 1 : 33);
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bad;
        logic [2:0]  f;
        logic [31:0] a, b;
        reset = 1'b1;
        start = 1'b0;
        funct3 = '0;
        rs1_data = '0;
        rs2_data = '0;
        rd_in = '0;
        repeat (3) @(negedge clock);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_wen", {31'd0, wEn_out}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rd_out", {27'd0, rd_out}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // MUL 7*13 with busy window checked cycle by cycle
        issue(3'b000, 32'd7, 32'd13, 5'd5, 32'h0000_005B);
        bad = 0;
        for (int k = 0; k < 33; k++) begin
            if (!busy) bad++;
            @(negedge clock);
        end
        check("busy_window_low_cycles", bad, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);

        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
        issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001);
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF);
        issue(3'b101, 32'd13, 32'd7, 5'd8, 32'd1);
        issue(3'b111, 32'd13, 32'd7, 5'd9, 32'd6);
        issue(3'b100, 32'd13, 32'd0, 5'd10, 32'hFFFF_FFFF);
        issue(3'b111, 32'd13, 32'd0, 5'd11, 32'h0000_000D);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0);

        // Reset one edge mid-DIV: operation abandoned, follow-up start accepted
        issue(3'b100, 32'd100, 32'd7, 5'd14, 32'd14);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_wen", {31'd0, wEn_out}, 32'd0);
        check("midreset_result", result, 32'd0);
        reset = 1'b0;
        sb.delete();
        issue(3'b101, 32'd100, 32'd7, 5'd15, 32'd14);

        issue(3'b000, 32'd3, 32'd4, 5'd0, 32'd12);

        for (int n = 0; n < 60; n++) begin
            f = 3'($urandom);
            a = pick_operand();
            b = pick_operand();
            issue(f, a, b, 5'($urandom_range(0, 31)), model(f, a, b));
        end

        wait_idle();
        start = 1'b0;
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clock);
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d_pending required=0_pending", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
